// File: rtl/queen_column_stepper_if.sv
// rtl/queen_column_stepper_if.sv - request/status bundle between the row controller and one column stepper
interface queen_column_stepper_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic          clear;
   logic          load;
   logic [W-1:0]  load_index;
   logic          step;
   logic [N-1:0]  mask;
   logic [N-1:0]  onehot;
   logic [W-1:0]  index;
   logic          valid;
   logic          exhausted;
   logic          load_error;

   modport master (
      output clear, load, load_index, step, mask,
      input  onehot, index, valid, exhausted, load_error
   );

   modport slave (
      input  clear, load, load_index, step, mask,
      output onehot, index, valid, exhausted, load_error
   );
endinterface

// File: rtl/queen_column_stepper.sv
// rtl/queen_column_stepper.sv - registered queen column holder with load, clear and masked step-to-next-free-column
module queen_column_stepper #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   queen_column_stepper_if.slave bus
);
   localparam int W  = $clog2(N);
   localparam int W1 = W + 1;

   logic [W-1:0] index_q, index_d;
   logic         valid_q, valid_d;
   logic [N-1:0] onehot_q, onehot_d;
   logic         exhausted_q, exhausted_d;
   logic         load_error_q, load_error_d;

   logic [W1-1:0] search_start;
   logic          search_found;
   logic [W-1:0]  search_pick;
   logic          load_in_range;

   // Start is one bit wider than the index so index N-1 yields start N and finds nothing.
   always_comb begin
      search_start = '0;
      if (valid_q)
         search_start = W1'(index_q) + W1'(1);
   end

   // Descending scan leaves the lowest eligible column in search_pick.
   always_comb begin
      search_found = 1'b0;
      search_pick  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!bus.mask[i] && (W1'(i) >= search_start)) begin
            search_found = 1'b1;
            search_pick  = W'(i);
         end
      end
   end

   assign load_in_range = ({1'b0, bus.load_index} < W1'(N));

   always_comb begin
      index_d      = index_q;
      valid_d      = valid_q;
      exhausted_d  = 1'b0;
      load_error_d = 1'b0;
      if (bus.clear) begin
         index_d = '0;
         valid_d = 1'b0;
      end else if (bus.load) begin
         if (load_in_range) begin
            index_d = bus.load_index;
            valid_d = 1'b1;
         end else begin
            load_error_d = 1'b1;
         end
      end else if (bus.step) begin
         if (search_found) begin
            index_d = search_pick;
            valid_d = 1'b1;
         end else begin
            index_d     = '0;
            valid_d     = 1'b0;
            exhausted_d = 1'b1;
         end
      end
   end

   always_comb begin
      onehot_d = '0;
      if (valid_d)
         onehot_d = N'(1) << index_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index_q      <= '0;
         valid_q      <= 1'b0;
         onehot_q     <= '0;
         exhausted_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         index_q      <= index_d;
         valid_q      <= valid_d;
         onehot_q     <= onehot_d;
         exhausted_q  <= exhausted_d;
         load_error_q <= load_error_d;
      end
   end

   assign bus.index      = index_q;
   assign bus.valid      = valid_q;
   assign bus.onehot     = onehot_q;
   assign bus.exhausted  = exhausted_q;
   assign bus.load_error = load_error_q;
endmodule

// File: tb/tb_queen_column_stepper.sv
// tb/tb_queen_column_stepper.sv - directed self-checking bench for queen_column_stepper at N=8 and N=6
module tb_queen_column_stepper;
   logic clk = 1'b0;
   logic rst;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   queen_column_stepper_if #(.N(8)) bus8();
   queen_column_stepper_if #(.N(6)) bus6();

   queen_column_stepper #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   queen_column_stepper #(.N(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] oh, input logic [2:0] idx,
                       input logic v, input logic ex, input logic le);
      chk({tag, ".onehot"}, bus8.onehot, oh);
      chk({tag, ".index"}, bus8.index, idx);
      chk({tag, ".valid"}, bus8.valid, v);
      chk({tag, ".exhausted"}, bus8.exhausted, ex);
      chk({tag, ".load_error"}, bus8.load_error, le);
   endtask

   task automatic chk6(input string tag, input logic [5:0] oh, input logic [2:0] idx,
                       input logic v, input logic ex, input logic le);
      chk({tag, ".onehot"}, bus6.onehot, oh);
      chk({tag, ".index"}, bus6.index, idx);
      chk({tag, ".valid"}, bus6.valid, v);
      chk({tag, ".exhausted"}, bus6.exhausted, ex);
      chk({tag, ".load_error"}, bus6.load_error, le);
   endtask

   initial begin
      rst = 1'b1;
      bus8.clear = 0; bus8.load = 1; bus8.load_index = 3'd3; bus8.step = 1; bus8.mask = 8'h00;
      bus6.clear = 0; bus6.load = 1; bus6.load_index = 3'd1; bus6.step = 1; bus6.mask = 6'h00;
      tick(); tick();
      chk8("reset8", 8'h00, 3'd0, 0, 0, 0);
      chk6("reset6", 6'h00, 3'd0, 0, 0, 0);

      rst = 0; bus8.load = 0; bus8.step = 0; bus6.load = 0; bus6.step = 0;
      repeat (5) tick();
      chk8("idle8", 8'h00, 3'd0, 0, 0, 0);

      bus8.load = 1; bus8.load_index = 3'd5;
      tick();
      bus8.load = 0;
      chk8("load5", 8'h20, 3'd5, 1, 0, 0);

      bus8.clear = 1; bus8.load = 1; bus8.load_index = 3'd2;
      tick();
      bus8.clear = 0; bus8.load = 0;
      chk8("clear_wins", 8'h00, 3'd0, 0, 0, 0);

      bus8.step = 1; bus8.mask = 8'b0000_1011;
      tick();
      chk8("step_to2", 8'h04, 3'd2, 1, 0, 0);
      bus8.mask = 8'b0011_1000;
      tick();
      chk8("step_to6", 8'h40, 3'd6, 1, 0, 0);
      bus8.mask = 8'h00;
      tick();
      chk8("step_to7", 8'h80, 3'd7, 1, 0, 0);
      tick();
      chk8("exhaust_at7", 8'h00, 3'd0, 0, 1, 0);
      bus8.mask = 8'b1111_1110;
      tick();
      chk8("restart0", 8'h01, 3'd0, 1, 0, 0);
      bus8.step = 0;

      bus8.load = 1; bus8.load_index = 3'd3;
      tick();
      bus8.load = 0;
      chk8("load3", 8'h08, 3'd3, 1, 0, 0);
      bus8.step = 1; bus8.mask = 8'b1111_0000;
      tick();
      bus8.step = 0; bus8.mask = 8'h00;
      chk8("exhaust_masked", 8'h00, 3'd0, 0, 1, 0);
      tick();
      chk8("exhaust_one_cycle", 8'h00, 3'd0, 0, 0, 0);

      bus8.load = 1; bus8.step = 1; bus8.load_index = 3'd4;
      tick();
      bus8.load = 0;
      chk8("load_beats_step", 8'h10, 3'd4, 1, 0, 0);
      tick();
      chk8("burst_5", 8'h20, 3'd5, 1, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      chk8("mid_reset", 8'h00, 3'd0, 0, 0, 0);
      tick();
      chk8("after_reset0", 8'h01, 3'd0, 1, 0, 0);
      tick();
      bus8.step = 0;
      chk8("after_reset1", 8'h02, 3'd1, 1, 0, 0);

      bus6.load = 1; bus6.load_index = 3'd2;
      tick();
      chk6("n6_load2", 6'b00_0100, 3'd2, 1, 0, 0);
      bus6.load_index = 3'd7;
      tick();
      bus6.load = 0;
      chk6("n6_illegal", 6'b00_0100, 3'd2, 1, 0, 1);
      tick();
      chk6("n6_err_one_cycle", 6'b00_0100, 3'd2, 1, 0, 0);
      bus6.load = 1; bus6.load_index = 3'd5;
      tick();
      bus6.load = 0;
      chk6("n6_load5", 6'b10_0000, 3'd5, 1, 0, 0);
      bus6.step = 1;
      tick();
      bus6.step = 0;
      chk6("n6_exhaust_top", 6'b00_0000, 3'd0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/queen_column_stepper.md
Name: queen_column_stepper

Overview:
- Parametrised, registered successor to the 3-to-8 column decoder used in the 8Queen solver.
- Holds the current queen column of one board row as a binary index and a one-hot vector for an N-column board.
- Supports direct load, clear, and a masked "step to next free column" operation.
- The backtracking controller instantiates one per row. It uses `exhausted` to know when a row has run out of columns and it must backtrack.

Parameters:
N, 8, board width (number of columns); legal range 2..64
W, $clog2(N), width of the binary column index; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  remove the queen from this row
load  input  1  place the queen at load_index
load_index  input  W  column for load
step  input  1  advance to the next free column strictly right of the current one
mask  input  N  attacked columns; mask[i]=1 means column i is forbidden for step
onehot  output  N  onehot[i]=1 iff the queen sits in column i; all zero when not valid
index  output  W  binary column of the queen; 0 when not valid
valid  output  1  a queen is placed in this row
exhausted  output  1  one-cycle pulse: a step found no free column
load_error  output  1  one-cycle pulse: load_index >= N

Behaviour:
- All outputs are registered. A request sampled at edge k is visible after edge k; no combinational path from any input to any output.
- Reset (rst=1 at an edge) drives onehot=0, index=0, valid=0, exhausted=0, load_error=0.
- Reset overrides every other input. Reset mid-operation discards the current placement.
- Request priority at an edge is rst > clear > load > step. Lower-priority requests asserted in the same cycle are ignored entirely, with no pulses.
- exhausted and load_error are 0 in every cycle in which their event did not occur.
- clear: valid=0, onehot=0, index=0. No pulses.
- load with load_index < N:
  - valid=1, index=load_index, onehot = 1<<load_index.
  - mask is ignored; the controller is trusted.
- load with load_index >= N (only possible when N is not a power of two):
  - State is left unchanged.
  - load_error=1 for one cycle.
- step search start:
  - valid=0: search begins at column 0.
  - valid=1: search begins at index+1.
- step search: the lowest column c >= start with mask[c]=0 is chosen.
  - If found: valid=1, index=c, onehot = 1<<c.
  - If none exists: valid=0, onehot=0, index=0, exhausted=1 for one cycle.
  - A step with valid=1 and index=N-1 always exhausts; there is no wrap-around to column 0.
- After exhaustion, the next step restarts the search from column 0. This is how the controller re-scans a row after backtracking.
- Holding step high for multiple cycles advances once per cycle.
- Invariant: onehot has at most one bit set, and onehot==0 iff valid==0.
- mask is sampled only on the step edge; its value in other cycles has no effect.
- Implementation limits: the search is a single-cycle priority encoder over N bits. No internal state besides index and valid; onehot is decoded from them and registered.

Test Plan:
- Reset and idle, N=8: assert rst for 2 cycles with load=1, step=1 -> onehot=8'b0, index=0, valid=0, no pulses; hold all requests low 5 cycles -> outputs unchanged.
- Load and clear: load, load_index=5 -> next cycle onehot=8'b0010_0000, index=5, valid=1; then clear=1 with load=1, load_index=2 in the same cycle -> valid=0, onehot=0 (clear wins).
- Masked stepping: from reset, mask=8'b0000_1011, step -> index=2; mask=8'b0011_1000, step -> index=6; step again -> index=7.
- Exhaustion and restart: at index=7 (mask=8'b0) step -> valid=0, exhausted=1 for exactly one cycle; step again with mask=8'b1111_1110 -> index=0, valid=1, exhausted=0. Then at index=3 with mask=8'b1111_0000, step -> exhausted pulse, valid=0.
- Illegal load, N=6: valid with index=2, load with load_index=7 -> state unchanged (index=2), load_error=1 for one cycle; load with load_index=5 -> onehot=6'b10_0000.
- Priority and mid-operation reset: load=1 and step=1 together with load_index=4 -> index=4 (step ignored). Then rst pulsed during a 4-cycle step burst -> outputs zero the cycle after rst; subsequent steps restart from column 0.
